// File: rtl/sm83_flag_register.sv
// sm83_flag_register: SM83 Z/N/H/C flag register with one-deep ALU commit stage, POP AF load, SCF/CCF and branch conditions.
// Optional DAA adjust outputs are enabled by defining SM83_FLAG_DAA_ASSIST_EN.
module sm83_flag_register #(
  parameter logic [7:0] RESET_F = 8'h00,
  parameter bit CC_FORWARD = 1'b1
) (
  input  logic       CLK,
  input  logic       nRESET,
  input  logic       alu_valid,
  input  logic [7:0] Res,
  input  logic       AllZeros,
  input  logic       alu_hout,
  input  logic       alu_cout,
  input  logic       op_sub,
  input  logic [3:0] upd_mask,
  input  logic [3:0] force_en,
  input  logic [3:0] force_val,
  input  logic       bus_load,
  input  logic [7:0] DV,
  input  logic       scf,
  input  logic       ccf,
  input  logic       cc_eval,
  input  logic [1:0] cc_sel,
  output logic [7:0] F,
  output logic       Temp_Z,
  output logic       Temp_N,
  output logic       Temp_H,
  output logic       Temp_C,
  output logic       cc_true,
`ifdef SM83_FLAG_DAA_ASSIST_EN
  output logic [7:0] daa_adj,
  output logic       daa_cout,
`endif
  output logic       pending
);
  logic [3:0] f, p_mask, p_val, src, cap, committed, post_sc, f_next, fs;
  logic cc;
  always_comb begin
    src = {AllZeros, op_sub, alu_hout, alu_cout};
    cap = (force_en & force_val) | (~force_en & src);
    committed = pending ? (p_mask & p_val) | (~p_mask & f) : f;
    post_sc = scf ? {committed[3], 3'b001} : ccf ? {committed[3], 2'b00, ~committed[0]} : committed;
    f_next = bus_load ? DV[7:4] : post_sc;
    fs = CC_FORWARD ? f_next : f;
    cc = cc_sel[1] ? (cc_sel[0] ? fs[0] : ~fs[0]) : (cc_sel[0] ? fs[3] : ~fs[3]);
  end
  always_ff @(posedge CLK or negedge nRESET)
    if (!nRESET) begin
      f <= RESET_F[7:4];
      pending <= 1'b0;
      p_mask <= 4'h0;
      p_val <= 4'h0;
      cc_true <= 1'b0;
    end else begin
      f <= f_next;
      pending <= alu_valid;
      p_mask <= alu_valid ? upd_mask : 4'h0;
      p_val <= alu_valid ? cap : 4'h0;
      cc_true <= cc_eval ? cc : cc_true;
    end
  assign F = {f, 4'b0000};
  assign {Temp_Z, Temp_N, Temp_H, Temp_C} = f;
`ifdef SM83_FLAG_DAA_ASSIST_EN
  logic lo, hi;
  assign lo = f[1] | (~f[2] & (Res[3:0] > 4'd9));
  assign hi = f[0] | (~f[2] & (Res > 8'h99));
  assign daa_adj = {hi ? 4'h6 : 4'h0, lo ? 4'h6 : 4'h0};
  assign daa_cout = hi;
`else
  logic unused_res;
  assign unused_res = ^Res;
`endif
endmodule
